// File: rtl/load_align_unit.sv
// Load alignment unit: fetches bus words, selects the addressed lanes and extends the result.
// Optional macro LOAD_ALIGN_MISALIGN_SPLIT_EN: service misaligned loads with one or two beats instead of faulting.
module load_align_unit #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [2:0]        req_op,
  output logic              bus_req,
  output logic [ADDR_W-1:0] bus_addr,
  input  logic              bus_ack,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_exc
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);

  // state | meaning
  // IDLE  | waiting for a load request
  // BEAT0 | reading the word holding the lowest addressed byte
  // BEAT1 | reading the following word (split access only)
  // RESP  | result held until the consumer takes it
  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        op_q, op_d;
  logic [DATA_W-1:0] lo_q, lo_d;
  logic [DATA_W-1:0] resp_data_q, resp_data_d;
  logic              resp_exc_q, resp_exc_d;

  logic [OFF_W-1:0]  req_off;
  logic [OFF_W-1:0]  cur_off;
  logic [ADDR_W-1:0] aligned_addr;

  // Access size in bytes; 32-bit ops collapse to a full word on a 32-bit bus.
  function automatic logic [4:0] op_bytes(input logic [2:0] op);
    logic [4:0] n;
    case (op)
      3'b001, 3'b010: n = 5'd1;
      3'b011, 3'b100: n = 5'd2;
      3'b101, 3'b110: n = (DATA_W == 64) ? 5'd4 : 5'(NB);
      default:        n = 5'(NB);
    endcase
    return n;
  endfunction

  function automatic logic op_signed(input logic [2:0] op);
    return (op == 3'b010) || (op == 3'b100) || ((op == 3'b110) && (DATA_W == 64));
  endfunction

  function automatic logic is_misaligned(input logic [2:0] op, input logic [OFF_W-1:0] off);
    logic [4:0] n;
    n = op_bytes(op);
    return (5'(off) & (n - 5'd1)) != 5'd0;
  endfunction

  function automatic logic spans_words(input logic [2:0] op, input logic [OFF_W-1:0] off);
    return (5'(off) + op_bytes(op)) > 5'(NB);
  endfunction

  // pair holds {next word, first word}; the addressed bytes start at lane 'off' of the first word.
  function automatic logic [DATA_W-1:0] extract(input logic [2*DATA_W-1:0] pair,
                                                input logic [OFF_W-1:0]    off,
                                                input logic [2:0]          op);
    logic [DATA_W-1:0] raw;
    logic [DATA_W-1:0] res;
    logic [4:0]        n;
    logic              sbit;
    raw = DATA_W'(pair >> {off, 3'b000});
    n   = op_bytes(op);
    case (n)
      5'd1:    sbit = raw[7];
      5'd2:    sbit = raw[15];
      5'd4:    sbit = raw[31];
      default: sbit = raw[DATA_W-1];
    endcase
    sbit = sbit & op_signed(op);
    for (int i = 0; i < DATA_W; i++) begin
      res[i] = (i < 8 * int'(n)) ? raw[i] : sbit;
    end
    return res;
  endfunction

  assign req_off      = req_addr[OFF_W-1:0];
  assign cur_off      = addr_q[OFF_W-1:0];
  assign aligned_addr = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    op_d        = op_q;
    lo_d        = lo_q;
    resp_data_d = resp_data_q;
    resp_exc_d  = resp_exc_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d      = req_addr;
          op_d        = req_op;
          resp_data_d = '0;
          resp_exc_d  = 1'b0;
          state_d     = BEAT0;
`ifndef LOAD_ALIGN_MISALIGN_SPLIT_EN
          if (is_misaligned(req_op, req_off)) begin
            resp_exc_d = 1'b1;
            state_d    = RESP;
          end
`endif
        end
      end
      BEAT0: begin
        if (bus_ack) begin
          resp_data_d = extract({{DATA_W{1'b0}}, bus_rdata}, cur_off, op_q);
          state_d     = RESP;
`ifdef LOAD_ALIGN_MISALIGN_SPLIT_EN
          if (spans_words(op_q, cur_off)) begin
            lo_d        = bus_rdata;
            resp_data_d = resp_data_q;
            state_d     = BEAT1;
          end
`endif
        end
      end
      BEAT1: begin
        if (bus_ack) begin
          resp_data_d = extract({bus_rdata, lo_q}, cur_off, op_q);
          state_d     = RESP;
        end
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      op_q        <= '0;
      lo_q        <= '0;
      resp_data_q <= '0;
      resp_exc_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      op_q        <= op_d;
      lo_q        <= lo_d;
      resp_data_q <= resp_data_d;
      resp_exc_q  <= resp_exc_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign bus_req    = (state_q == BEAT0) || (state_q == BEAT1);
  assign bus_addr   = (state_q == BEAT0) ? aligned_addr :
                      (state_q == BEAT1) ? aligned_addr + ADDR_W'(NB) : '0;
  assign resp_valid = (state_q == RESP);
  assign resp_exc   = resp_exc_q;
  assign resp_data  = resp_exc_q ? '0 : resp_data_q;

endmodule

// File: tb/tb_load_align_unit.sv
// Directed bench for load_align_unit: 32-bit and 64-bit instances, lane select/extension,
// misalignment handling, stalls and mid-access reset.
module tb_load_align_unit;

  logic        clk = 1'b0;
  logic        reset;

  logic        a_req_valid, a_req_ready, a_bus_req, a_bus_ack, a_resp_valid, a_resp_ready, a_resp_exc;
  logic [31:0] a_req_addr, a_bus_addr, a_bus_rdata, a_resp_data;
  logic [2:0]  a_req_op;

  logic        b_req_valid, b_req_ready, b_bus_req, b_bus_ack, b_resp_valid, b_resp_ready, b_resp_exc;
  logic [31:0] b_req_addr, b_bus_addr;
  logic [63:0] b_bus_rdata, b_resp_data;
  logic [2:0]  b_req_op;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  load_align_unit #(.DATA_W(32), .ADDR_W(32)) u32 (
    .clk(clk), .reset(reset),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_addr(a_req_addr), .req_op(a_req_op),
    .bus_req(a_bus_req), .bus_addr(a_bus_addr), .bus_ack(a_bus_ack), .bus_rdata(a_bus_rdata),
    .resp_valid(a_resp_valid), .resp_ready(a_resp_ready), .resp_data(a_resp_data), .resp_exc(a_resp_exc)
  );

  load_align_unit #(.DATA_W(64), .ADDR_W(32)) u64 (
    .clk(clk), .reset(reset),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_addr(b_req_addr), .req_op(b_req_op),
    .bus_req(b_bus_req), .bus_addr(b_bus_addr), .bus_ack(b_bus_ack), .bus_rdata(b_bus_rdata),
    .resp_valid(b_resp_valid), .resp_ready(b_resp_ready), .resp_data(b_resp_data), .resp_exc(b_resp_exc)
  );

  task automatic test_reset();
    reset = 1'b1;
    #1;
    vec_cnt++; if (a_req_ready !== 1'b1) begin err_cnt++; $display("FAIL rst32_req_ready got %b want 1", a_req_ready); end
    vec_cnt++; if (a_bus_req !== 1'b0) begin err_cnt++; $display("FAIL rst32_bus_req got %b want 0", a_bus_req); end
    vec_cnt++; if (a_bus_addr !== 32'h0) begin err_cnt++; $display("FAIL rst32_bus_addr got %h want 0", a_bus_addr); end
    vec_cnt++; if (a_resp_valid !== 1'b0) begin err_cnt++; $display("FAIL rst32_resp_valid got %b want 0", a_resp_valid); end
    vec_cnt++; if (a_resp_data !== 32'h0) begin err_cnt++; $display("FAIL rst32_resp_data got %h want 0", a_resp_data); end
    vec_cnt++; if (a_resp_exc !== 1'b0) begin err_cnt++; $display("FAIL rst32_resp_exc got %b want 0", a_resp_exc); end
    vec_cnt++; if ({b_req_ready, b_bus_req, b_resp_valid, b_resp_exc} !== 4'b1000) begin
      err_cnt++; $display("FAIL rst64_flags got %b want 1000", {b_req_ready, b_bus_req, b_resp_valid, b_resp_exc}); end
    vec_cnt++; if (b_resp_data !== 64'h0) begin err_cnt++; $display("FAIL rst64_resp_data got %h want 0", b_resp_data); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  // Single-beat load on the 32-bit instance with immediate ack and immediate consume.
  task automatic test_load32(input string name, input logic [31:0] addr, input logic [2:0] op,
                             input logic [31:0] rdata, input logic [31:0] exp);
    a_req_addr = addr; a_req_op = op; a_req_valid = 1'b1;
    vec_cnt++; if (a_req_ready !== 1'b1) begin err_cnt++; $display("FAIL %s req_ready got %b want 1", name, a_req_ready); end
    @(negedge clk);
    a_req_valid = 1'b0;
    vec_cnt++; if (a_bus_req !== 1'b1) begin err_cnt++; $display("FAIL %s bus_req got %b want 1", name, a_bus_req); end
    vec_cnt++; if (a_bus_addr !== {addr[31:2], 2'b00}) begin
      err_cnt++; $display("FAIL %s bus_addr got %h want %h", name, a_bus_addr, {addr[31:2], 2'b00}); end
    a_bus_ack = 1'b1; a_bus_rdata = rdata;
    @(negedge clk);
    a_bus_ack = 1'b0; a_bus_rdata = 32'h5A5A_A5A5;
    vec_cnt++; if (a_resp_valid !== 1'b1) begin err_cnt++; $display("FAIL %s resp_valid got %b want 1", name, a_resp_valid); end
    vec_cnt++; if (a_resp_data !== exp) begin err_cnt++; $display("FAIL %s resp_data got %h want %h", name, a_resp_data, exp); end
    vec_cnt++; if (a_resp_exc !== 1'b0) begin err_cnt++; $display("FAIL %s resp_exc got %b want 0", name, a_resp_exc); end
    a_resp_ready = 1'b1;
    @(negedge clk);
    a_resp_ready = 1'b0;
    vec_cnt++; if ({a_resp_valid, a_req_ready} !== 2'b01) begin
      err_cnt++; $display("FAIL %s release got %b want 01", name, {a_resp_valid, a_req_ready}); end
  endtask

  task automatic test_load64(input string name, input logic [31:0] addr, input logic [2:0] op,
                             input logic [63:0] rdata, input logic [63:0] exp);
    b_req_addr = addr; b_req_op = op; b_req_valid = 1'b1;
    @(negedge clk);
    b_req_valid = 1'b0;
    vec_cnt++; if ({b_bus_req, b_bus_addr} !== {1'b1, addr[31:3], 3'b000}) begin
      err_cnt++; $display("FAIL %s bus got %b/%h want 1/%h", name, b_bus_req, b_bus_addr, {addr[31:3], 3'b000}); end
    b_bus_ack = 1'b1; b_bus_rdata = rdata;
    @(negedge clk);
    b_bus_ack = 1'b0; b_bus_rdata = '0;
    vec_cnt++; if ({b_resp_valid, b_resp_exc} !== 2'b10) begin
      err_cnt++; $display("FAIL %s valid_exc got %b want 10", name, {b_resp_valid, b_resp_exc}); end
    vec_cnt++; if (b_resp_data !== exp) begin err_cnt++; $display("FAIL %s resp_data got %h want %h", name, b_resp_data, exp); end
    b_resp_ready = 1'b1;
    @(negedge clk);
    b_resp_ready = 1'b0;
  endtask

  task automatic test_misalign();
    // lh at offset 3 straddles words 0x0 and 0x4.
    a_req_addr = 32'h3; a_req_op = 3'b100; a_req_valid = 1'b1;
    @(negedge clk);
    a_req_valid = 1'b0;
`ifdef LOAD_ALIGN_MISALIGN_SPLIT_EN
    vec_cnt++; if ({a_bus_req, a_bus_addr} !== {1'b1, 32'h0}) begin
      err_cnt++; $display("FAIL split_beat0 got %b/%h want 1/0", a_bus_req, a_bus_addr); end
    a_bus_ack = 1'b1; a_bus_rdata = 32'h11AB_CDEF;
    @(negedge clk);
    a_bus_rdata = 32'h3344_5522;
    vec_cnt++; if ({a_bus_req, a_bus_addr, a_resp_valid} !== {1'b1, 32'h4, 1'b0}) begin
      err_cnt++; $display("FAIL split_beat1 got %b/%h/%b want 1/4/0", a_bus_req, a_bus_addr, a_resp_valid); end
    @(negedge clk);
    a_bus_ack = 1'b0;
    vec_cnt++; if ({a_resp_valid, a_resp_exc, a_resp_data} !== {2'b10, 32'h0000_2211}) begin
      err_cnt++; $display("FAIL split_resp got %b%b/%h want 10/00002211", a_resp_valid, a_resp_exc, a_resp_data); end
`else
    vec_cnt++; if (a_bus_req !== 1'b0) begin err_cnt++; $display("FAIL fault_bus_req got %b want 0", a_bus_req); end
    vec_cnt++; if ({a_resp_valid, a_resp_exc, a_resp_data} !== {2'b11, 32'h0}) begin
      err_cnt++; $display("FAIL fault_resp got %b%b/%h want 11/00000000", a_resp_valid, a_resp_exc, a_resp_data); end
`endif
    a_resp_ready = 1'b1;
    @(negedge clk);
    a_resp_ready = 1'b0;
    // lhu at offset 1 is misaligned but stays inside one word.
    a_req_addr = 32'h1; a_req_op = 3'b011; a_req_valid = 1'b1;
    @(negedge clk);
    a_req_valid = 1'b0;
`ifdef LOAD_ALIGN_MISALIGN_SPLIT_EN
    a_bus_ack = 1'b1; a_bus_rdata = 32'h00AB_CD00;
    @(negedge clk);
    a_bus_ack = 1'b0;
    vec_cnt++; if ({a_resp_valid, a_resp_exc, a_resp_data} !== {2'b10, 32'h0000_ABCD}) begin
      err_cnt++; $display("FAIL inword_resp got %b%b/%h want 10/0000abcd", a_resp_valid, a_resp_exc, a_resp_data); end
`else
    vec_cnt++; if ({a_bus_req, a_resp_valid, a_resp_exc, a_resp_data} !== {3'b011, 32'h0}) begin
      err_cnt++; $display("FAIL inword_fault got %b%b%b/%h want 011/0", a_bus_req, a_resp_valid, a_resp_exc, a_resp_data); end
`endif
    a_resp_ready = 1'b1;
    @(negedge clk);
    a_resp_ready = 1'b0;
  endtask

  task automatic test_stall();
    a_req_addr = 32'h6; a_req_op = 3'b001; a_req_valid = 1'b1;
    @(negedge clk);
    a_req_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      vec_cnt++; if ({a_bus_req, a_bus_addr, a_req_ready, a_resp_valid} !== {1'b1, 32'h4, 2'b00}) begin
        err_cnt++; $display("FAIL stall_bus[%0d] got %b/%h/%b%b", i, a_bus_req, a_bus_addr, a_req_ready, a_resp_valid); end
      @(negedge clk);
    end
    a_bus_ack = 1'b1; a_bus_rdata = 32'h0055_0000;
    @(negedge clk);
    a_bus_ack = 1'b0; a_bus_rdata = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      vec_cnt++; if ({a_resp_valid, a_req_ready, a_resp_exc, a_resp_data} !== {3'b100, 32'h55}) begin
        err_cnt++; $display("FAIL stall_resp[%0d] got %b%b%b/%h want 100/00000055", i, a_resp_valid, a_req_ready, a_resp_exc, a_resp_data); end
      @(negedge clk);
    end
    a_resp_ready = 1'b1;
    @(negedge clk);
    a_resp_ready = 1'b0;
  endtask

  // Requester keeps req_valid high across the response handshake.
  task automatic test_back_to_back();
    a_req_addr = 32'h8; a_req_op = 3'b000; a_req_valid = 1'b1;
    @(negedge clk);
    a_bus_ack = 1'b1; a_bus_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    a_bus_ack = 1'b0;
    a_resp_ready = 1'b1;
    @(negedge clk);
    a_resp_ready = 1'b0;
    vec_cnt++; if ({a_req_ready, a_bus_req, a_resp_valid} !== 3'b100) begin
      err_cnt++; $display("FAIL b2b_idle got %b want 100", {a_req_ready, a_bus_req, a_resp_valid}); end
    @(negedge clk);
    a_req_valid = 1'b0;
    vec_cnt++; if ({a_bus_req, a_bus_addr} !== {1'b1, 32'h8}) begin
      err_cnt++; $display("FAIL b2b_second got %b/%h want 1/8", a_bus_req, a_bus_addr); end
    a_bus_ack = 1'b1; a_bus_rdata = 32'h1357_9BDF;
    @(negedge clk);
    a_bus_ack = 1'b0;
    vec_cnt++; if (a_resp_data !== 32'h1357_9BDF) begin
      err_cnt++; $display("FAIL b2b_data got %h want 13579bdf", a_resp_data); end
    a_resp_ready = 1'b1;
    @(negedge clk);
    a_resp_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    a_req_addr = 32'hC; a_req_op = 3'b000; a_req_valid = 1'b1;
    @(negedge clk);
    a_req_valid = 1'b0;
    vec_cnt++; if (a_bus_req !== 1'b1) begin err_cnt++; $display("FAIL midrst_pre got %b want 1", a_bus_req); end
    reset = 1'b1;
    #1;
    vec_cnt++; if ({a_req_ready, a_bus_req, a_bus_addr, a_resp_valid, a_resp_exc, a_resp_data} !== {2'b10, 32'h0, 2'b00, 32'h0}) begin
      err_cnt++; $display("FAIL midrst_async got %b%b/%h/%b%b/%h", a_req_ready, a_bus_req, a_bus_addr, a_resp_valid, a_resp_exc, a_resp_data); end
    @(negedge clk);
    reset = 1'b0;
    a_bus_ack = 1'b1; a_bus_rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    a_bus_ack = 1'b0;
    for (int i = 0; i < 2; i++) begin
      vec_cnt++; if ({a_req_ready, a_bus_req, a_resp_valid, a_resp_data} !== {3'b100, 32'h0}) begin
        err_cnt++; $display("FAIL midrst_stray[%0d] got %b%b%b/%h want 100/0", i, a_req_ready, a_bus_req, a_resp_valid, a_resp_data); end
      @(negedge clk);
    end
  endtask

  initial begin
    reset = 1'b1;
    a_req_valid = 1'b0; a_req_addr = '0; a_req_op = '0; a_bus_ack = 1'b0; a_bus_rdata = '0; a_resp_ready = 1'b0;
    b_req_valid = 1'b0; b_req_addr = '0; b_req_op = '0; b_bus_ack = 1'b0; b_bus_rdata = '0; b_resp_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_load32("lb_a3",   32'h3, 3'b010, 32'h80AA_BBCC, 32'hFFFF_FF80);
    test_load32("lhu_a2",  32'h2, 3'b011, 32'h8001_1234, 32'h0000_8001);
    test_load32("lbu_a1",  32'h1, 3'b001, 32'h80AA_BBCC, 32'h0000_00BB);
    test_load32("lh_a0",   32'h0, 3'b100, 32'h8001_1234, 32'h0000_1234);
    test_load32("lh_a2",   32'h2, 3'b100, 32'h8001_1234, 32'hFFFF_8001);
    test_load32("full_a4", 32'h4, 3'b000, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    test_load32("lw_a8",   32'h8, 3'b110, 32'h8000_0001, 32'h8000_0001);
    test_load32("lwu_a10", 32'h10, 3'b101, 32'hF00F_0FF0, 32'hF00F_0FF0);
    test_load32("op7_a14", 32'h14, 3'b111, 32'h8765_4321, 32'h8765_4321);
    test_load64("lw64_a4",  32'h4,  3'b110, 64'h8765_4321_0000_0000, 64'hFFFF_FFFF_8765_4321);
    test_load64("lwu64_a4", 32'h4,  3'b101, 64'h8765_4321_0000_0000, 64'h0000_0000_8765_4321);
    test_load64("lh64_a6",  32'h6,  3'b100, 64'h9ABC_0000_0000_0000, 64'hFFFF_FFFF_FFFF_9ABC);
    test_load64("full64_a8", 32'h8, 3'b000, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF);
    test_misalign();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
